// File: rtl/devices_read_arbiter.sv
// Read-response arbiter for slot devices: waits for a device to claim a CPU read,
// latches one byte by fixed priority (lowest index wins) and logs multi-device claims.
module devices_read_arbiter #(
   parameter int N_DEV   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               cpu_rd,
   input  logic [N_DEV-1:0]   dev_rq,
   input  logic [8*N_DEV-1:0] dev_data,
   input  logic               conflict_clr,
   output logic [7:0]         data,
   output logic               output_rq,
   output logic               cpu_wait,
   output logic [N_DEV-1:0]   grant,
   output logic               timeout,
   output logic               conflict,
   output logic [7:0]         conflict_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             output_rq_q, output_rq_d;
   logic             cpu_wait_q, cpu_wait_d;
   logic [N_DEV-1:0] grant_q, grant_d;
   logic             timeout_q, timeout_d;
   logic             conflict_q, conflict_d;
   logic [7:0]       conflict_cnt_q, conflict_cnt_d;

   logic [N_DEV-1:0] cap_oh;
   logic [7:0]       cap_byte;
   logic [3:0]       n_rq;
   logic             capture;

   // Walk from the top index down so the lowest requesting device is the last writer.
   always_comb begin
      cap_oh   = '0;
      cap_byte = 8'hFF;
      n_rq     = 4'd0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         n_rq = n_rq + {3'b000, dev_rq[i]};
         if (dev_rq[i]) begin
            cap_oh    = '0;
            cap_oh[i] = 1'b1;
            cap_byte  = dev_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      data_d         = data_q;
      output_rq_d    = output_rq_q;
      cpu_wait_d     = cpu_wait_q;
      grant_d        = grant_q;
      timeout_d      = 1'b0;
      conflict_d     = conflict_q;
      conflict_cnt_d = conflict_cnt_q;
      capture        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu_rd) begin
               if (|dev_rq) begin
                  capture = 1'b1;
               end else begin
                  state_d    = S_WAIT;
                  cnt_d      = 8'd0;
                  cpu_wait_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (!cpu_rd) begin
               state_d    = S_IDLE;
               cnt_d      = 8'd0;
               cpu_wait_d = 1'b0;
            end else if (|dev_rq) begin
               capture = 1'b1;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               // Open-bus answer: release the CPU with 0xFF and nobody granted.
               state_d     = S_HOLD;
               cpu_wait_d  = 1'b0;
               data_d      = 8'hFF;
               output_rq_d = 1'b0;
               grant_d     = '0;
               timeout_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (!cpu_rd) begin
               state_d     = S_IDLE;
               data_d      = 8'hFF;
               output_rq_d = 1'b0;
               grant_d     = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (capture) begin
         state_d     = S_HOLD;
         cpu_wait_d  = 1'b0;
         data_d      = cap_byte;
         grant_d     = cap_oh;
         output_rq_d = 1'b1;
      end

      // A conflicting capture wins over a coincident clear, restarting the count at one.
      if (capture && (n_rq > 4'd1)) begin
         conflict_d = 1'b1;
         if (conflict_clr)
            conflict_cnt_d = 8'd1;
         else if (conflict_cnt_q != 8'hFF)
            conflict_cnt_d = conflict_cnt_q + 8'd1;
      end else if (conflict_clr) begin
         conflict_d     = 1'b0;
         conflict_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         data_q         <= 8'hFF;
         output_rq_q    <= 1'b0;
         cpu_wait_q     <= 1'b0;
         grant_q        <= '0;
         timeout_q      <= 1'b0;
         conflict_q     <= 1'b0;
         conflict_cnt_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         data_q         <= data_d;
         output_rq_q    <= output_rq_d;
         cpu_wait_q     <= cpu_wait_d;
         grant_q        <= grant_d;
         timeout_q      <= timeout_d;
         conflict_q     <= conflict_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign data         = data_q;
   assign output_rq    = output_rq_q;
   assign cpu_wait     = cpu_wait_q;
   assign grant        = grant_q;
   assign timeout      = timeout_q;
   assign conflict     = conflict_q;
   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_devices_read_arbiter.sv
// Bench for devices_read_arbiter: stimulus pushes expected responses into a queue,
// a monitor pops one on every capture or timeout and compares.
module tb_devices_read_arbiter;

   localparam int N_DEV   = 4;
   localparam int TIMEOUT = 8;
   localparam int W       = 31;

   logic               clk_sys = 1'b0;
   logic               reset_n = 1'b0;
   logic               cpu_rd = 1'b0;
   logic [N_DEV-1:0]   dev_rq = '0;
   logic [8*N_DEV-1:0] dev_data = '0;
   logic               conflict_clr = 1'b0;
   logic [7:0]         data;
   logic               output_rq;
   logic               cpu_wait;
   logic [N_DEV-1:0]   grant;
   logic               timeout;
   logic               conflict;
   logic [7:0]         conflict_cnt;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   devices_read_arbiter #(.N_DEV(N_DEV), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .cpu_rd(cpu_rd), .dev_rq(dev_rq),
      .dev_data(dev_data), .conflict_clr(conflict_clr), .data(data),
      .output_rq(output_rq), .cpu_wait(cpu_wait), .grant(grant), .timeout(timeout),
      .conflict(conflict), .conflict_cnt(conflict_cnt)
   );

   // clock / watchdog
   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog sim time limit reached");
      $fatal(1, "watchdog");
   end

   // response record: wait cycles, timeout, output_rq, grant, data, conflict, conflict_cnt
   function automatic logic [W-1:0] mk(input logic [7:0] w, input logic to, input logic orq,
                                       input logic [3:0] g, input logic [7:0] d,
                                       input logic cf, input logic [7:0] cc);
      return {w, to, orq, g, d, cf, cc};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic at_neg();
      @(negedge clk_sys);
   endtask

   task automatic sample();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic release_rd();
      at_neg();
      cpu_rd = 1'b0;
      dev_rq = '0;
      sample();
      chk("release_data", {24'd0, data}, 32'hFF);
      chk("release_orq_grant", {27'd0, output_rq, grant}, 32'd0);
   endtask

   // monitor / scoreboard
   logic [7:0]   wait_run = 8'd0;
   logic         prev_orq = 1'b0;
   logic [W-1:0] act_r, exp_r;

   always @(posedge clk_sys) begin
      #1;
      if (!reset_n) begin
         wait_run = 8'd0;
         prev_orq = 1'b0;
      end else begin
         if ((output_rq && !prev_orq) || timeout) begin
            act_r = mk(wait_run, timeout, output_rq, grant, data, conflict, conflict_cnt);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_response actual=%h expected=none", act_r);
            end else begin
               exp_r = exp_q.pop_front();
               if (act_r !== exp_r) begin
                  errors++;
                  $display("FAIL response actual=%h expected=%h", act_r, exp_r);
               end
            end
            wait_run = 8'd0;
         end else if (cpu_wait) begin
            wait_run = wait_run + 8'd1;
         end else begin
            wait_run = 8'd0;
         end
         prev_orq = output_rq;
      end
   end

   // stimulus
   initial begin
      at_neg();
      at_neg();
      chk("reset_data", {24'd0, data}, 32'hFF);
      chk("reset_flags", {28'd0, output_rq, cpu_wait, timeout, conflict}, 32'd0);
      chk("reset_grant", {28'd0, grant}, 32'd0);
      chk("reset_cnt", {24'd0, conflict_cnt}, 32'd0);
      reset_n = 1'b1;

      // reset while device 2 holds 0x5A (with a conflict logged)
      at_neg();
      cpu_rd = 1'b1;
      dev_rq = 4'b1100;
      dev_data[23:16] = 8'h5A;
      exp_q.push_back(mk(8'd0, 1'b0, 1'b1, 4'b0100, 8'h5A, 1'b1, 8'd1));
      sample();
      chk("hold_5a", {24'd0, data}, 32'h5A);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_data", {24'd0, data}, 32'hFF);
      chk("async_rst_orq_grant", {27'd0, output_rq, grant}, 32'd0);
      chk("async_rst_cnt", {23'd0, conflict, conflict_cnt}, 32'd0);
      at_neg();
      reset_n = 1'b1;
      cpu_rd = 1'b0;
      dev_rq = '0;
      sample();
      chk("post_rst_idle", {24'd0, data}, 32'hFF);

      // fast device 2
      at_neg();
      cpu_rd = 1'b1;
      dev_rq = 4'b0100;
      dev_data[23:16] = 8'hA5;
      exp_q.push_back(mk(8'd0, 1'b0, 1'b1, 4'b0100, 8'hA5, 1'b0, 8'd0));
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("fast_no_wait", {31'd0, cpu_wait}, 32'd0);
      end
      release_rd();

      // slow device 1, claim three wait cycles in; data frozen afterwards
      at_neg();
      cpu_rd = 1'b1;
      repeat (3) at_neg();
      dev_rq = 4'b0010;
      dev_data[15:8] = 8'h3C;
      exp_q.push_back(mk(8'd3, 1'b0, 1'b1, 4'b0010, 8'h3C, 1'b0, 8'd0));
      at_neg();
      dev_data[15:8] = 8'h00;
      sample();
      sample();
      chk("frozen_data", {24'd0, data}, 32'h3C);
      chk("frozen_grant", {28'd0, grant}, 32'b0010);
      release_rd();

      // unclaimed: full timeout, then a late claim while held is ignored
      at_neg();
      cpu_rd = 1'b1;
      exp_q.push_back(mk(8'd8, 1'b1, 1'b0, 4'b0000, 8'hFF, 1'b0, 8'd0));
      repeat (11) sample();
      at_neg();
      dev_rq = 4'b0001;
      dev_data[7:0] = 8'h99;
      sample();
      sample();
      chk("to_hold_data", {24'd0, data}, 32'hFF);
      chk("to_hold_flags", {29'd0, output_rq, cpu_wait, timeout}, 32'd0);
      release_rd();

      // conflicting captures up to saturation
      for (int j = 1; j <= 256; j++) begin
         at_neg();
         cpu_rd = 1'b1;
         dev_rq = 4'b1011;
         dev_data[7:0] = 8'(j);
         exp_q.push_back(mk(8'd0, 1'b0, 1'b1, 4'b0001, 8'(j), 1'b1, (j > 255) ? 8'd255 : 8'(j)));
         at_neg();
         cpu_rd = 1'b0;
         dev_rq = '0;
      end
      sample();
      chk("sat_cnt", {24'd0, conflict_cnt}, 32'd255);

      // clear coincident with a conflicting capture
      at_neg();
      cpu_rd = 1'b1;
      dev_rq = 4'b0110;
      dev_data[15:8] = 8'h77;
      conflict_clr = 1'b1;
      exp_q.push_back(mk(8'd0, 1'b0, 1'b1, 4'b0010, 8'h77, 1'b1, 8'd1));
      at_neg();
      conflict_clr = 1'b0;
      release_rd();

      // plain clear
      at_neg();
      conflict_clr = 1'b1;
      at_neg();
      conflict_clr = 1'b0;
      chk("clr_only", {23'd0, conflict, conflict_cnt}, 32'd0);

      // abort after two wait cycles: no timeout, back to idle
      at_neg();
      cpu_rd = 1'b1;
      repeat (2) at_neg();
      cpu_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("abort_idle", {30'd0, cpu_wait, timeout}, 32'd0);
      end

      // fresh full-length wait, claimed on the last wait cycle
      at_neg();
      cpu_rd = 1'b1;
      repeat (8) at_neg();
      dev_rq = 4'b1000;
      dev_data[31:24] = 8'hC3;
      exp_q.push_back(mk(8'd8, 1'b0, 1'b1, 4'b1000, 8'hC3, 1'b0, 8'd0));
      sample();
      release_rd();

      repeat (4) sample();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/devices_read_arbiter.md
# devices_read_arbiter

Arbitrates CPU read responses among up to N_DEV slot devices (SCC, FDC, memory mapper and similar) that currently share one data path through an AND-combine. The block sits between those devices and the CPU bus. It detects each CPU read cycle and waits, inserting CPU wait states, until a device claims the cycle or a timeout expires. It then latches exactly one device's byte (fixed priority), holds it stable until the cycle ends, and counts multi-device claims for debug.

## Interface
Parameters:
- N_DEV, 4: number of requesting devices; 1..8.
- TIMEOUT, 8: maximum WAIT cycles before open-bus response; 1..255.

Ports:
- clk_sys  in  1  system clock; only clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  level; high for the whole CPU read cycle (memory or I/O).
- dev_rq  in  N_DEV  per-device claim of current cycle; bit i = device i; may assert any cycle cpu_rd is high.
- dev_data  in  8*N_DEV  device i byte on bits [8i+7:8i]; valid whenever dev_rq[i]=1.
- conflict_clr  in  1  single-cycle pulse; clears conflict and conflict_cnt.
- data  out  8  registered response byte; 0xFF when no response is held.
- output_rq  out  1  registered; high while a device-claimed byte is held.
- cpu_wait  out  1  registered; high while in WAIT.
- grant  out  N_DEV  registered one-hot index of the captured device; 0 otherwise.
- timeout  out  1  one-cycle pulse when a cycle ends unclaimed.
- conflict  out  1  sticky; set when >1 dev_rq bit high at capture.
- conflict_cnt  out  8  saturating count of conflicting captures.

## Operation
- States: IDLE, WAIT, HOLD.
- IDLE:
  - cpu_rd=1 and |dev_rq → capture, go to HOLD.
  - cpu_rd=1 and dev_rq=0 → go to WAIT, wait counter ← 0.
  - cpu_rd=0 → stay.
- WAIT:
  - cpu_rd=0 → go to IDLE. Abort: no capture, no timeout pulse.
  - Else |dev_rq → capture, go to HOLD.
  - Else if counter = TIMEOUT−1 → go to HOLD with data=0xFF, output_rq=0, grant=0; pulse timeout.
  - Else counter+1.
- Capture:
  - Select the lowest set index i of dev_rq.
  - data ← dev_data[i], grant ← one-hot i, output_rq ← 1.
  - Once captured, data is frozen; later dev_rq/dev_data changes are ignored until the block returns to IDLE.
- HOLD:
  - cpu_rd=0 → go to IDLE; data ← 0xFF, output_rq ← 0, grant ← 0.
  - Else stay.
- A new CPU cycle needs cpu_rd low for at least one cycle, i.e. a return through IDLE. cpu_rd held high after HOLD never re-captures.
- Conflict logging:
  - Applies to any capture with popcount(dev_rq) ≥ 2.
  - conflict ← 1; conflict_cnt ← min(cnt+1, 255).
  - conflict_clr in the same cycle as a conflicting capture → conflict=1, conflict_cnt=1. Otherwise clr → 0/0.
- Reset (reset_n=0, asynchronous, any state, including mid-WAIT or mid-HOLD):
  - state=IDLE, counter=0, data=0xFF, output_rq=0, cpu_wait=0, grant=0, timeout=0, conflict=0, conflict_cnt=0.

## Timing
- All outputs are registered and change on the clk_sys rising edge after the deciding input sample.
- Fast device (dev_rq high in the first cpu_rd cycle): output_rq/data valid 1 cycle after cpu_rd rises; cpu_wait never asserts.
- Slow device: cpu_wait rises 1 cycle after cpu_rd. A claim sampled k cycles into WAIT (k=0..TIMEOUT−1) drops cpu_wait and raises output_rq on the same edge.
- Unclaimed cycle: cpu_wait is high for exactly TIMEOUT cycles, then the timeout pulse coincides with cpu_wait falling.
- Release: output_rq/grant clear and data returns to 0xFF 1 cycle after cpu_rd falls.

## Test plan
- Reset mid-HOLD (device 2 holding 0x5A) → next sample: data=0xFF, output_rq=0, grant=0, conflict_cnt=0.
- cpu_rd rises with dev_rq=0100, dev_data[2]=0xA5 → 1 cycle later data=0xA5, output_rq=1, grant=0100, cpu_wait never 1; cpu_rd low → data=0xFF next cycle.
- TIMEOUT=8; dev_rq[1] rises 3 cycles after cpu_rd with 0x3C → cpu_wait high 3 cycles, then data=0x3C, grant=0010; changing dev_data[1] to 0x00 during HOLD leaves data=0x3C.
- No claims, TIMEOUT=8 → cpu_wait high 8 cycles, timeout pulses once, output_rq=0, data=0xFF; held until cpu_rd falls.
- dev_rq=1011 at capture → grant=0001, data=dev_data[0], conflict=1, conflict_cnt=1. 256 such cycles → conflict_cnt=255. conflict_clr coincident with another conflicting capture → conflict_cnt=1.
- cpu_rd falls after 2 WAIT cycles → IDLE, no timeout pulse. Next cpu_rd rise starts a fresh full-length WAIT.
